// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshot, clear and stream readout of the PE accumulator array
module systolic_result_drain #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*ACC_W-1:0] acc_in_i,
  input  logic               start_i,
  output logic               acc_clr_o,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               out_sat_o,
  output logic [ROW_W-1:0]   out_row_o,
  output logic [COL_W-1:0]   out_col_o,
  output logic               out_last_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((64'd1 << OUT_W) - 64'd1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             acc_clr_q, acc_clr_d;
  logic             snap_load;
  logic [ACC_W-1:0] snap_q [N];
  logic [ACC_W-1:0] elem;
  logic [ACC_W-1:0] shifted;

  // Control state: FSM, element index and the one-shot clear request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  // Snapshot is loaded only on an accepted start so later array activity cannot leak in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < N; i++) snap_q[i] <= acc_in_i[i*ACC_W +: ACC_W];
    end
  end

  // Next-state logic; SEND always presents an element, so out_ready alone is the handshake
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_clr_d = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_SEND;
          idx_d     = '0;
          acc_clr_d = 1'b1;
          snap_load = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output datapath: everything derives from registered state, zeroed outside SEND
  always_comb begin
    elem        = snap_q[idx_q];
    shifted     = elem >> SHIFT;
    acc_clr_o   = acc_clr_q;
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_sat_o   = 1'b0;
    out_row_o   = '0;
    out_col_o   = '0;
    out_last_o  = 1'b0;
    if (state_q == ST_SEND) begin
      out_valid_o = 1'b1;
      if (shifted > SAT_MAX) begin
        out_data_o = OUT_W'(SAT_MAX);
        out_sat_o  = 1'b1;
      end else begin
        out_data_o = shifted[OUT_W-1:0];
      end
      out_row_o  = ROW_W'(int'(idx_q) / COLS);
      out_col_o  = COL_W'(int'(idx_q) % COLS);
      out_last_o = (idx_q == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - self-checking bench for systolic_result_drain
module tb_systolic_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] acc_in;
  logic         start;
  logic         out_ready;

  logic         acc_clr, busy, out_valid, out_sat, out_last, done;
  logic [15:0]  out_data;
  logic [0:0]   out_row, out_col;

  logic         acc_clr_b, busy_b, out_valid_b, out_sat_b, out_last_b, done_b;
  logic [15:0]  out_data_b;
  logic [0:0]   out_row_b, out_col_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(.SHIFT(0)) dut (
    .clk(clk), .rst(rst), .acc_in_i(acc_in), .start_i(start),
    .acc_clr_o(acc_clr), .busy_o(busy), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_sat_o(out_sat),
    .out_row_o(out_row), .out_col_o(out_col), .out_last_o(out_last), .done_o(done)
  );

  systolic_result_drain #(.SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .acc_in_i(acc_in), .start_i(start),
    .acc_clr_o(acc_clr_b), .busy_o(busy_b), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .out_data_o(out_data_b), .out_sat_o(out_sat_b),
    .out_row_o(out_row_b), .out_col_o(out_col_b), .out_last_o(out_last_b), .done_o(done_b)
  );

  typedef struct {
    logic [15:0] d0;
    logic        s0;
    logic [15:0] d4;
    logic        s4;
    logic [0:0]  row;
    logic [0:0]  col;
    logic        last;
  } elem_t;

  typedef struct {
    logic [31:0] v;
    logic [15:0] d0;
    logic        s0;
    logic [15:0] d4;
    logic        s4;
  } sat_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: element i of a drain, from plain shift/clamp arithmetic on the captured word
  function automatic elem_t model_elem(input logic [127:0] acc, input int i);
    elem_t           e;
    longint unsigned v, s;
    v = longint'(acc[i*32 +: 32]);
    s = v;
    if (s > 65535) begin e.d0 = 16'hFFFF; e.s0 = 1'b1; end
    else begin e.d0 = 16'(s); e.s0 = 1'b0; end
    s = v >> 4;
    if (s > 65535) begin e.d4 = 16'hFFFF; e.s4 = 1'b1; end
    else begin e.d4 = 16'(s); e.s4 = 1'b0; end
    e.row  = 1'(i / 2);
    e.col  = 1'(i % 2);
    e.last = (i == 3);
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_clr"},    acc_clr,    0);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_valid"},  out_valid,  0);
    chk({tag, "_data"},   out_data,   0);
    chk({tag, "_sat"},    out_sat,    0);
    chk({tag, "_row"},    out_row,    0);
    chk({tag, "_col"},    out_col,    0);
    chk({tag, "_last"},   out_last,   0);
    chk({tag, "_done"},   done,       0);
    chk({tag, "_valid4"}, out_valid_b, 0);
    chk({tag, "_data4"},  out_data_b, 0);
    chk({tag, "_done4"},  done_b,     0);
  endtask

  // mode 0: ready high; 1: 3-cycle stall on element (1,0); 2: random ready; 3: acc_in change + start in SEND
  task automatic run_drain(input logic [127:0] acc, input int mode);
    elem_t q[$];
    int    hs, cyc, stall;
    logic  rdy, hsk;
    hs = 0; cyc = 0; stall = 0;
    @(negedge clk);
    acc_in = acc; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(model_elem(acc, i));
    @(negedge clk);
    start = 1'b0;
    chk("first_clr",   acc_clr,   1);
    chk("first_busy",  busy,      1);
    chk("first_valid", out_valid, 1);
    if (mode == 3) begin acc_in = '1; start = 1'b1; end
    while (hs < 4 && cyc < 200) begin
      chk("send_valid", out_valid, 1);
      chk("send_busy",  busy,      1);
      chk("send_done",  done,      0);
      chk("data",  out_data,   q[0].d0);
      chk("sat",   out_sat,    q[0].s0);
      chk("row",   out_row,    q[0].row);
      chk("col",   out_col,    q[0].col);
      chk("last",  out_last,   q[0].last);
      chk("data4", out_data_b, q[0].d4);
      chk("sat4",  out_sat_b,  q[0].s4);
      if (cyc > 0) chk("clr_once", acc_clr, 0);
      case (mode)
        1: begin rdy = !(hs == 2 && stall < 3); if (!rdy) stall++; end
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      hsk = out_valid && rdy;
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (mode == 3 && cyc == 2) start = 1'b0;
      if (hsk) begin void'(q.pop_front()); hs++; end
    end
    out_ready = 1'b1;
    if (cyc >= 200) chk("drain_timeout", 1, 0);
    if (mode == 1) chk("stall_cycles", cyc, 7);
    chk("done_pulse", done,      1);
    chk("done_busy",  busy,      1);
    chk("done_valid", out_valid, 0);
    chk("done_clr",   acc_clr,   0);
    @(negedge clk);
    chk("idle_done",  done,      0);
    chk("idle_busy",  busy,      0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sat_vec_t     tbl[7];
    logic [127:0] a;
    int           p;
    elem_t        e;

    tbl[0] = '{32'h00012345, 16'hFFFF, 1'b1, 16'h1234, 1'b0};
    tbl[1] = '{32'h0000FFFF, 16'hFFFF, 1'b0, 16'h0FFF, 1'b0};
    tbl[2] = '{32'h00010000, 16'hFFFF, 1'b1, 16'h1000, 1'b0};
    tbl[3] = '{32'h000FFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
    tbl[4] = '{32'h00100000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{32'h00000000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    rst = 1'b1; acc_in = '0; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic ordered drain: 1,2,3,4
    run_drain({32'd4, 32'd3, 32'd2, 32'd1}, 0);

    // Saturation table on element (0,0)
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      acc_in = {96'd0, tbl[t].v}; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("tbl_data",  out_data,   tbl[t].d0);
      chk("tbl_sat",   out_sat,    tbl[t].s0);
      chk("tbl_data4", out_data_b, tbl[t].d4);
      chk("tbl_sat4",  out_sat_b,  tbl[t].s4);
      repeat (5) @(negedge clk);
      chk("tbl_idle", busy, 0);
    end

    // Backpressure on element (1,0)
    run_drain({32'h40000, 32'h3000, 32'h200, 32'h10}, 1);

    // Snapshot isolation and start while busy
    run_drain({32'h11111, 32'h2222, 32'hF333, 32'h4444}, 3);

    // Reset after the second handshake
    @(negedge clk);
    acc_in = {32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD}; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (3) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    run_drain({32'h5, 32'h6, 32'h7, 32'h8}, 0);

    // Back-to-back with start held high
    @(negedge clk);
    a = {32'h1_0000, 32'h123, 32'hFFFF, 32'h7};
    acc_in = a; start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      p = c % 6;
      chk("b2b_clr",   acc_clr,   (p == 0));
      chk("b2b_done",  done,      (p == 4));
      chk("b2b_valid", out_valid, (p < 4));
      chk("b2b_busy",  busy,      (p < 5));
      if (p < 4) begin
        e = model_elem(a, p);
        chk("b2b_data", out_data, e.d0);
        chk("b2b_last", out_last, e.last);
      end
      if (c == 17) start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_stop", busy, 0);

    // Randomized drains against the reference model
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++)
        a[i*32 +: 32] = (r % 2 == 1) ? $urandom : $urandom_range(0, 32'h000FFFFF);
      run_drain(a, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
